ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM boundary of the 64-bit pipelined core: latches ALU result/flags plus memory/writeback control
//  from the execute stage and hands them to the MEM stage over a valid/ready handshake.
//  Resolves BEQ (ALU Zero) at capture, emits a registered redirect and self-squashes the wrong-path beat.
//  2-entry skid buffer: downstream backpressure never forms a combinational path to in_ready.
// PARAMETERS
//  XLEN     64  datapath width (result, store data, PC/target)
//  REG_AW   5   register-file index width (rd)
// PORTS
//  clk             in   1       rising-edge clock, single clock domain
//  rst_n           in   1       asynchronous active-low reset
//  flush           in   1       synchronous pipeline flush (exception/trap from later stage)
//  in_valid        in   1       EX beat valid
//  in_ready        out  1       stage can accept (registered)
//  in_alu_op       in   3       ALU control code (pkg encodings)
//  in_result       in   XLEN    ALU Result
//  in_zero/in_negative/in_carry/in_overflow  in 1 each  ALU flags
//  in_store_data   in   XLEN    rs2 value for stores
//  in_rd           in   REG_AW  destination register
//  in_regwrite/in_memread/in_memwrite/in_branch  in 1 each  control bits
//  in_br_target    in   XLEN    precomputed branch target
//  out_valid       out  1       MEM beat valid
//  out_ready       in   1       MEM stage accepts
//  out_result/out_store_data  out XLEN; out_rd out REG_AW; out_regwrite/out_memread/out_memwrite out 1
//  out_zero/out_negative      out  1    flags carried with the beat
//  out_exc         out  1       beat carries overflow exception (see CONFIGURATION)
//  redirect_valid  out  1       one-cycle pulse: taken branch, fetch from redirect_pc
//  redirect_pc     out  XLEN    branch target
// BEHAVIOUR
//  Reset (rst_n=0, async): state EMPTY; in_ready=1; out_valid=0; redirect_valid=0; all data outs 0.
//  Accept = in_valid & in_ready & ~flush & ~redirect_valid. Emit = out_valid & out_ready.
//  States: EMPTY(0 entries) ONE(main) TWO(main+skid). out_* always driven from main entry.
//   EMPTY: accept->ONE. ONE: accept&~emit->TWO; emit&~accept->EMPTY; both->ONE (main replaced).
//   TWO: in_ready=0; emit->ONE, skid moves to main. in_ready = (next state != TWO), registered.
//  Latency: 1 cycle in_valid->out_valid when EMPTY; FIFO order preserved; no beat lost or duplicated.
//  Branch: accepted beat with in_branch & in_zero -> redirect_valid=1, redirect_pc=in_br_target next cycle,
//   for exactly one cycle. Branch beat itself still goes to MEM with regwrite/memread/memwrite forced 0.
//  Self-squash: beat presented while redirect_valid=1 is wrong-path; consumed and dropped (not stored).
//  flush=1: synchronous; both entries invalidated, state->EMPTY, incoming beat dropped, redirect_valid->0.
//   flush dominates accept, emit, squash in the same cycle.
//  Reset mid-operation: all entries lost, outputs return to reset values asynchronously.
//  Widths: no arithmetic in block; all fields captured verbatim (XLEN bits), no truncation.
// CONFIGURATION
//  EXMEM_OVF_TRAP_EN defined: accepted beat with in_overflow=1 and in_alu_op in {ADD,SUB} stores
//   out_exc=1 and forces regwrite/memread/memwrite=0 for that beat; beat still emitted to MEM.
//  Not defined: out_exc tied 0; in_overflow and in_carry ignored (carry kept only for debug).
// STRUCTURE
//  Package ex_mem_pkg: ALU op codes ADD=3'b000 SUB=3'b001 BEQ=3'b010 AND=3'b100 OR=3'b101;
//   state encoding EMPTY/ONE/TWO; packed beat struct (result, store_data, rd, ctrl, flags, exc).
//  One sub-module: ex_mem_skid (generic 2-entry skid buffer over the packed beat, valid/ready both sides);
//   top handles branch resolution, squash, overflow trap and control forcing.
// TESTING
//  Reset then ADD beat result=0x5, rd=3, regwrite=1, out_ready=1 -> next cycle out_valid=1, out_result=0x5, out_rd=3.
//  out_ready=0, 3 back-to-back beats A,B,C -> A,B held, in_ready=0 on C; release -> A,B,C in order, no loss.
//  BEQ beat in_branch=1,in_zero=1,target=0x1000 -> redirect_valid 1 cycle, pc=0x1000; next beat dropped; regwrite 0.
//  BEQ with in_zero=0 -> no redirect; following beat accepted normally.
//  State TWO then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
//  With EXMEM_OVF_TRAP_EN: ADD, in_overflow=1, regwrite=1 -> out_exc=1, out_regwrite=0; without: out_exc=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// EX->MEM stage shared types: ALU op codes, skid buffer state encoding and the packed beat.
package ex_mem_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluBeq = 3'b010,
    AluAnd = 3'b100,
    AluOr  = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
  } ctrl_t;

  typedef struct packed {
    logic zero;
    logic negative;
  } flags_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
    flags_t            flags;
    logic              exc;
  } beat_t;

  // Overflow only traps for the arithmetic ops.
  function automatic logic is_addsub(input logic [2:0] op);
    return (op == AluAdd) || (op == AluSub);
  endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Two-entry skid buffer over beat_t. o_ready is registered so downstream backpressure never
// reaches the upstream ready combinationally. The output is always the main entry.
module ex_mem_skid
  import ex_mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_flush,
  input  logic  i_valid,
  output logic  o_ready,
  input  beat_t i_beat,
  output logic  o_valid,
  input  logic  i_ready,
  output beat_t o_beat
);

  state_e r_state, w_state_d;
  beat_t  r_main, w_main_d;
  beat_t  r_skid, w_skid_d;
  logic   r_ready;
  logic   w_push, w_pop;

  assign w_push = i_valid & r_ready & ~i_flush;
  assign w_pop  = (r_state != StEmpty) & i_ready & ~i_flush;

  // Next-state and entry update; flush discards everything including the incoming beat.
  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    if (i_flush) begin
      w_state_d = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_push) begin
            w_state_d = StOne;
            w_main_d  = i_beat;
          end
        end
        StOne: begin
          if (w_push && !w_pop) begin
            w_state_d = StTwo;
            w_skid_d  = i_beat;
          end else if (w_push && w_pop) begin
            w_main_d = i_beat;
          end else if (w_pop) begin
            w_state_d = StEmpty;
          end
        end
        StTwo: begin
          // r_ready is low here, so only a pop can happen.
          if (w_pop) begin
            w_state_d = StOne;
            w_main_d  = r_skid;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  // State, entries and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_main  <= w_main_d;
      r_skid  <= w_skid_d;
      r_ready <= (w_state_d != StTwo);
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_state != StEmpty);
  assign o_beat  = r_main;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: resolves BEQ at capture, issues a one-cycle redirect, squashes the
// wrong-path beat and buffers beats in a 2-entry skid. Optional overflow trap: EXMEM_OVF_TRAP_EN.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned XLEN   = ex_mem_pkg::XLEN,
  parameter int unsigned REG_AW = ex_mem_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_alu_op,
  input  logic [XLEN-1:0]   in_result,
  input  logic              in_zero,
  input  logic              in_negative,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_branch,
  input  logic [XLEN-1:0]   in_br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_zero,
  output logic              out_negative,
  output logic              out_exc,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            w_skid_ready;
  logic            w_accept;
  logic            w_taken;
  logic            w_exc;
  logic            w_kill_ctrl;
  beat_t           w_in_beat;
  beat_t           w_out_beat;

`ifdef EXMEM_OVF_TRAP_EN
  assign w_exc = in_overflow & is_addsub(in_alu_op);
  logic w_unused_dbg;
  assign w_unused_dbg = in_carry;
`else
  assign w_exc = 1'b0;
  logic w_unused_dbg;
  assign w_unused_dbg = ^{in_carry, in_overflow, in_alu_op};
`endif

  assign w_taken     = in_branch & in_zero;
  assign w_kill_ctrl = w_taken | w_exc;
  // A beat presented while a redirect is out is wrong-path and never enters the buffer.
  assign w_accept    = in_valid & w_skid_ready & ~flush & ~r_redirect_valid;

  // Capture fields verbatim, masking side effects of taken branches and trapped beats.
  always_comb begin
    w_in_beat                = '0;
    w_in_beat.result         = in_result;
    w_in_beat.store_data     = in_store_data;
    w_in_beat.rd             = in_rd;
    w_in_beat.ctrl.regwrite  = in_regwrite & ~w_kill_ctrl;
    w_in_beat.ctrl.memread   = in_memread & ~w_kill_ctrl;
    w_in_beat.ctrl.memwrite  = in_memwrite & ~w_kill_ctrl;
    w_in_beat.flags.zero     = in_zero;
    w_in_beat.flags.negative = in_negative;
    w_in_beat.exc            = w_exc;
  end

  ex_mem_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (in_valid & ~r_redirect_valid),
    .o_ready (w_skid_ready),
    .i_beat  (w_in_beat),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_beat  (w_out_beat)
  );

  // One-cycle redirect pulse for a taken branch; the squash rule prevents back-to-back pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_accept & w_taken;
      if (w_accept && w_taken) begin
        r_redirect_pc <= in_br_target;
      end
    end
  end

  assign in_ready       = w_skid_ready;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign out_result     = w_out_beat.result;
  assign out_store_data = w_out_beat.store_data;
  assign out_rd         = w_out_beat.rd;
  assign out_regwrite   = w_out_beat.ctrl.regwrite;
  assign out_memread    = w_out_beat.ctrl.memread;
  assign out_memwrite   = w_out_beat.ctrl.memwrite;
  assign out_zero       = w_out_beat.flags.zero;
  assign out_negative   = w_out_beat.flags.negative;
  assign out_exc        = w_out_beat.exc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage; honours EXMEM_OVF_TRAP_EN when defined.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [2:0]  in_alu_op;
  logic [63:0] in_result, in_store_data, in_br_target;
  logic        in_zero, in_negative, in_carry, in_overflow;
  logic [4:0]  in_rd;
  logic        in_regwrite, in_memread, in_memwrite, in_branch;
  logic        out_valid, out_ready;
  logic [63:0] out_result, out_store_data, redirect_pc;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_memread, out_memwrite, out_zero, out_negative, out_exc;
  logic        redirect_valid;

`ifdef EXMEM_OVF_TRAP_EN
  localparam bit OvfTrap = 1'b1;
`else
  localparam bit OvfTrap = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_result(in_result), .in_zero(in_zero),
    .in_negative(in_negative), .in_carry(in_carry), .in_overflow(in_overflow),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .in_memwrite(in_memwrite), .in_branch(in_branch),
    .in_br_target(in_br_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_zero(out_zero), .out_negative(out_negative), .out_exc(out_exc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [63:0] result;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, z, n, exc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_emit = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  // Expected MEM-side beat for the inputs currently driven.
  function automatic exp_t model_now();
    exp_t e;
    logic kill;
    kill = in_branch & in_zero;
    e.exc = 1'b0;
    if (OvfTrap && in_overflow && (in_alu_op == 3'b000 || in_alu_op == 3'b001)) begin
      e.exc = 1'b1;
      kill  = 1'b1;
    end
    e.result = in_result;
    e.sd     = in_store_data;
    e.rd     = in_rd;
    e.rw     = in_regwrite & ~kill;
    e.mr     = in_memread & ~kill;
    e.mw     = in_memwrite & ~kill;
    e.z      = in_zero;
    e.n      = in_negative;
    return e;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [63:0] res, input logic [63:0] sd,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic br, input logic z, input logic ov, input logic [63:0] tgt);
    in_valid = 1'b1; in_alu_op = op; in_result = res; in_store_data = sd; in_rd = rd;
    in_regwrite = rw; in_memread = mr; in_memwrite = mw; in_branch = br; in_zero = z;
    in_negative = res[63]; in_carry = ov; in_overflow = ov; in_br_target = tgt;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Score the current cycle (inputs settled, away from the edge) then advance one clock.
  task automatic tick(output bit acc);
    exp_t e;
    acc = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_emit++;
        if (q.size() == 0) begin
          n_total++;
          $error("FAIL unexpected_beat: observed result %0h expected no beat", out_result);
        end else begin
          e = q.pop_front();
          chk("beat_result", out_result, e.result);
          chk("beat_store_data", out_store_data, e.sd);
          chk("beat_rd", 64'(out_rd), 64'(e.rd));
          chk("beat_ctrl", 64'({out_regwrite, out_memread, out_memwrite}),
              64'({e.rw, e.mr, e.mw}));
          chk("beat_flags_exc", 64'({out_zero, out_negative, out_exc}), 64'({e.z, e.n, e.exc}));
        end
      end
      if (in_valid && in_ready && !redirect_valid) begin
        q.push_back(model_now());
        acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit a;
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) tick(a);
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit acc;
    int base;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(3'b000, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD beat, one-cycle latency.
    out_ready = 1'b1;
    drive(3'b000, 64'h5, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tick(acc);
    idle();
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_result", out_result, 64'h5);
    chk("lat_out_rd", 64'(out_rd), 64'd3);
    drain();

    // Backpressure: A, B fill the buffer, C blocked, then release in order.
    base = n_emit;
    out_ready = 1'b0;
    drive(3'b001, 64'hDEADBEEF_CAFEF00D, 64'h1111, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick(acc);
    drive(3'b100, 64'h8000_0000_0000_0001, 64'h2222, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick(acc);
    chk("two_in_ready", 64'(in_ready), 64'd0);
    chk("two_head_is_a", out_result, 64'hDEADBEEF_CAFEF00D);
    drive(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
          0);
    tick(acc);
    chk("c_blocked", 64'(acc), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!acc) tick(acc);
    end
    chk("c_accepted", 64'(acc), 64'd1);
    drain();
    chk("abc_emit_count", 64'(n_emit - base), 64'd3);

    // Taken BEQ: redirect pulse, wrong-path beat dropped, branch ctrl masked.
    base = n_emit;
    drive(3'b010, 64'h0, 64'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h1000);
    tick(acc);
    chk("br_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("br_redirect_pc", redirect_pc, 64'h1000);
    chk("br_out_regwrite", 64'(out_regwrite), 64'd0);
    drive(3'b000, 64'hBAD, 64'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tick(acc);
    chk("br_wrong_path_dropped", 64'(acc), 64'd0);
    chk("br_redirect_one_cycle", 64'(redirect_valid), 64'd0);
    drain();
    chk("br_emit_count", 64'(n_emit - base), 64'd1);

    // Not-taken BEQ: no redirect, next beat accepted.
    base = n_emit;
    drive(3'b010, 64'h1, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h2000);
    tick(acc);
    chk("nt_redirect_valid", 64'(redirect_valid), 64'd0);
    drive(3'b000, 64'h77, 64'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tick(acc);
    chk("nt_next_accepted", 64'(acc), 64'd1);
    drain();
    chk("nt_emit_count", 64'(n_emit - base), 64'd2);

    // Flush while full, with a beat presented: everything discarded.
    base = n_emit;
    out_ready = 1'b0;
    drive(3'b000, 64'hF1, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tick(acc);
    drive(3'b000, 64'hF2, 64'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tick(acc);
    chk("fl_pre_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(3'b000, 64'hF3, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    tick(acc);
    flush = 1'b0;
    idle();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) tick(acc);
    chk("fl_emit_count", 64'(n_emit - base), 64'd0);

    // Overflow handling on ADD, SUB (trap-eligible) and AND (never traps).
    drive(3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick(acc);
    chk("ovf_add_exc", 64'(out_exc), 64'(OvfTrap));
    chk("ovf_add_regwrite", 64'(out_regwrite), 64'(!OvfTrap));
    drive(3'b001, 64'h8000_0000_0000_0000, 64'h55, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick(acc);
    chk("ovf_sub_memread", 64'(out_memread), 64'(!OvfTrap));
    drive(3'b100, 64'h0F, 64'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
    tick(acc);
    chk("ovf_and_exc", 64'(out_exc), 64'd0);
    drain();

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    drive(3'b000, 64'hABCD, 64'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h3000);
    tick(acc);
    idle();
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_redirect_valid", 64'(redirect_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
